// File: rtl/shift_exec_unit_pkg.sv
// Shared constants for the shift execute unit and its shifter.
package shift_exec_unit_pkg;
   localparam int DATA_W  = 16;
   localparam int SHAMT_W = 4;

   typedef enum logic [1:0] {
      SLL = 2'b00,
      SRL = 2'b01,
      SLA = 2'b10,
      SRA = 2'b11
   } shift_mode_e;
endpackage

// File: rtl/shifter.sv
// Combinational 16-bit barrel shifter with logical, fill-with-bit-0 and arithmetic modes.
module shifter
   import shift_exec_unit_pkg::*;
(
   output logic [DATA_W-1:0]  dst,
   input  logic [DATA_W-1:0]  src,
   input  logic [1:0]         m,
   input  logic [SHAMT_W-1:0] shamt
);
   logic [DATA_W-1:0] low_fill;

   always_comb begin
      // Mask of the low bits vacated by a left shift.
      low_fill = ~({DATA_W{1'b1}} << shamt);
      case (m)
         SLL:     dst = src << shamt;
         SRL:     dst = src >> shamt;
         SLA:     dst = (src << shamt) | ({DATA_W{src[0]}} & low_fill);
         SRA:     dst = $signed(src) >>> shamt;
         default: dst = src;
      endcase
   end
endmodule

// File: rtl/shift_exec_unit.sv
// Two-stage pipelined shift execute unit with valid/ready on both sides,
// architectural Z/N flags and a retired-operation counter.
module shift_exec_unit
   import shift_exec_unit_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DATA_W-1:0]   in_src,
   input  logic [1:0]          in_mode,
   input  logic [SHAMT_W-1:0]  in_shamt,
   input  logic [3:0]          in_rd,
   input  logic                flush,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_W-1:0]   out_data,
   output logic [3:0]          out_rd,
   output logic                out_zero,
   output logic                out_neg,
   output logic                flag_z,
   output logic                flag_n,
   output logic [CNT_W-1:0]    retired_cnt
);
   logic                s1_v_q, s1_v_d;
   logic [DATA_W-1:0]   s1_src_q, s1_src_d;
   logic [1:0]          s1_mode_q, s1_mode_d;
   logic [SHAMT_W-1:0]  s1_shamt_q, s1_shamt_d;
   logic [3:0]          s1_rd_q, s1_rd_d;
   logic                s2_v_q, s2_v_d;
   logic [DATA_W-1:0]   s2_data_q, s2_data_d;
   logic [3:0]          s2_rd_q, s2_rd_d;
   logic                flag_z_q, flag_z_d;
   logic                flag_n_q, flag_n_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   shift_res;
   logic                s1_adv, s2_adv, retire;

   shifter u_shifter (
      .dst   (shift_res),
      .src   (s1_src_q),
      .m     (s1_mode_q),
      .shamt (s1_shamt_q)
   );

   always_comb begin
      s2_adv     = !s2_v_q | out_ready;
      s1_adv     = !s1_v_q | s2_adv;
      in_ready   = s1_adv & !flush;
      retire     = s2_v_q & out_ready & !flush;

      s1_v_d     = s1_v_q;
      s1_src_d   = s1_src_q;
      s1_mode_d  = s1_mode_q;
      s1_shamt_d = s1_shamt_q;
      s1_rd_d    = s1_rd_q;
      s2_v_d     = s2_v_q;
      s2_data_d  = s2_data_q;
      s2_rd_d    = s2_rd_q;
      flag_z_d   = flag_z_q;
      flag_n_d   = flag_n_q;
      cnt_d      = cnt_q;

      if (s1_adv) begin
         s1_v_d     = in_valid & in_ready;
         s1_src_d   = in_src;
         s1_mode_d  = in_mode;
         s1_shamt_d = in_shamt;
         s1_rd_d    = in_rd;
      end
      if (s2_adv) begin
         s2_v_d    = s1_v_q;
         s2_data_d = shift_res;
         s2_rd_d   = s1_rd_q;
      end
      // Flush only kills valids; data fields are don't-care once invalid.
      if (flush) begin
         s1_v_d = 1'b0;
         s2_v_d = 1'b0;
      end
      if (retire) begin
         flag_z_d = out_zero;
         flag_n_d = out_neg;
         cnt_d    = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_v_q     <= 1'b0;
         s1_src_q   <= '0;
         s1_mode_q  <= '0;
         s1_shamt_q <= '0;
         s1_rd_q    <= '0;
         s2_v_q     <= 1'b0;
         s2_data_q  <= '0;
         s2_rd_q    <= '0;
         flag_z_q   <= 1'b0;
         flag_n_q   <= 1'b0;
         cnt_q      <= '0;
      end else begin
         s1_v_q     <= s1_v_d;
         s1_src_q   <= s1_src_d;
         s1_mode_q  <= s1_mode_d;
         s1_shamt_q <= s1_shamt_d;
         s1_rd_q    <= s1_rd_d;
         s2_v_q     <= s2_v_d;
         s2_data_q  <= s2_data_d;
         s2_rd_q    <= s2_rd_d;
         flag_z_q   <= flag_z_d;
         flag_n_q   <= flag_n_d;
         cnt_q      <= cnt_d;
      end
   end

   assign out_valid   = s2_v_q;
   assign out_data    = s2_data_q;
   assign out_rd      = s2_rd_q;
   assign out_zero    = (s2_data_q == '0);
   assign out_neg     = s2_data_q[DATA_W-1];
   assign flag_z      = flag_z_q;
   assign flag_n      = flag_n_q;
   assign retired_cnt = cnt_q;
endmodule

// File: tb/tb_shift_exec_unit.sv
// Self-checking bench for shift_exec_unit: table vectors, directed corner cases, random traffic.
module tb_shift_exec_unit;
   import shift_exec_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_src = '0;
   logic [1:0]  in_mode = '0;
   logic [3:0]  in_shamt = '0;
   logic [3:0]  in_rd = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_data;
   logic [3:0]  out_rd;
   logic        out_zero, out_neg, flag_z, flag_n;
   logic [15:0] retired_cnt;

   always #5 clk = ~clk;

   shift_exec_unit #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_src(in_src), .in_mode(in_mode), .in_shamt(in_shamt), .in_rd(in_rd),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_rd(out_rd),
      .out_zero(out_zero), .out_neg(out_neg),
      .flag_z(flag_z), .flag_n(flag_n),
      .retired_cnt(retired_cnt)
   );

   typedef struct {
      logic [1:0]  mode;
      logic [15:0] src;
      logic [3:0]  shamt;
      logic [3:0]  rd;
      logic [15:0] exp;
   } vec_t;

   typedef struct {
      logic [15:0] data;
      logic [3:0]  rd;
      int          acc;
   } ent_t;

   ent_t        sb[$];
   int          stp = 0;
   logic        m_fz = 1'b0, m_fn = 1'b0;
   logic [15:0] m_cnt = '0;
   int          total = 0, bad = 0;
   vec_t        vecs[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (step %0d)", name, act, exp, stp);
      end
   endtask

   // Shift defined arithmetically: multiply/divide by 2^sh plus fill terms.
   function automatic logic [15:0] model(input logic [1:0] mode, input logic [15:0] src,
                                         input logic [3:0] sh);
      int p, s, r;
      p = 1 << sh;
      s = int'(src);
      case (mode)
         2'd0:    r = (s * p) % 65536;
         2'd1:    r = s / p;
         2'd2:    r = (s * p) % 65536 + (src[0] ? p - 1 : 0);
         default: r = s / p + (src[15] ? 65536 - 65536 / p : 0);
      endcase
      return r[15:0];
   endfunction

   task automatic step(input logic v, input logic [1:0] m, input logic [15:0] s,
                       input logic [3:0] sh, input logic [3:0] rd, input logic [15:0] e,
                       input logic ordy, input logic fl);
      logic ov_e, ir_e, ret, acc;
      ent_t ne;
      @(negedge clk);
      in_valid = v; in_mode = m; in_src = s; in_shamt = sh; in_rd = rd;
      out_ready = ordy; flush = fl;
      #1;
      ov_e = (sb.size() > 0) && (sb[0].acc <= stp - 2);
      ir_e = !fl && ((sb.size() < 2) || ordy);
      chk("out_valid", 32'(out_valid), 32'(ov_e));
      chk("in_ready", 32'(in_ready), 32'(ir_e));
      if (ov_e) begin
         chk("out_data", 32'(out_data), 32'(sb[0].data));
         chk("out_rd", 32'(out_rd), 32'(sb[0].rd));
         chk("out_zero", 32'(out_zero), 32'(sb[0].data == 16'h0));
         chk("out_neg", 32'(out_neg), 32'(sb[0].data[15]));
      end
      chk("flag_z", 32'(flag_z), 32'(m_fz));
      chk("flag_n", 32'(flag_n), 32'(m_fn));
      chk("retired_cnt", 32'(retired_cnt), 32'(m_cnt));
      ret = ov_e & ordy & !fl;
      acc = v & ir_e;
      if (acc) $display("step %0d accept rd=%0d mode=%0d src=%h sh=%0d", stp, rd, m, s, sh);
      if (ret) $display("step %0d retire rd=%0d data=%h", stp, out_rd, out_data);
      if (fl)  $display("step %0d flush", stp);
      @(posedge clk);
      if (fl) begin
         sb.delete();
      end else begin
         if (ret) begin
            m_fz = (sb[0].data == 16'h0);
            m_fn = sb[0].data[15];
            m_cnt = m_cnt + 16'd1;
            void'(sb.pop_front());
         end
         if (acc) begin
            ne.data = e; ne.rd = rd; ne.acc = stp;
            sb.push_back(ne);
         end
      end
      stp++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 2'd0, 16'h0, 4'd0, 4'd0, 16'h0, 1'b1, 1'b0);
   endtask

   task automatic issue(input vec_t x, input logic ordy);
      step(1'b1, x.mode, x.src, x.shamt, x.rd, x.exp, ordy, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      #2 rst = 1'b1;
      #1;
      $display("reset asserted");
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst in_ready", 32'(in_ready), 32'd1);
      chk("rst out_data", 32'(out_data), 32'd0);
      chk("rst out_rd", 32'(out_rd), 32'd0);
      chk("rst out_zero", 32'(out_zero), 32'd1);
      chk("rst out_neg", 32'(out_neg), 32'd0);
      chk("rst flag_z", 32'(flag_z), 32'd0);
      chk("rst flag_n", 32'(flag_n), 32'd0);
      chk("rst retired_cnt", 32'(retired_cnt), 32'd0);
      sb.delete();
      m_fz = 1'b0; m_fn = 1'b0; m_cnt = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [15:0] cnt_save;
      logic        fz_save, fn_save;
      vec_t        r;

      vecs[0]  = '{SRA, 16'h8000, 4'd4,  4'd1,  16'hF800};
      vecs[1]  = '{SLL, 16'h0001, 4'd15, 4'd2,  16'h8000};
      vecs[2]  = '{SRL, 16'h8000, 4'd15, 4'd3,  16'h0001};
      vecs[3]  = '{SLA, 16'h0001, 4'd3,  4'd4,  16'h000F};
      vecs[4]  = '{SRA, 16'h7FFF, 4'd15, 4'd5,  16'h0000};
      vecs[5]  = '{SLL, 16'hA5A5, 4'd0,  4'd6,  16'hA5A5};
      vecs[6]  = '{SRL, 16'hA5A5, 4'd0,  4'd7,  16'hA5A5};
      vecs[7]  = '{SLA, 16'hA5A5, 4'd0,  4'd8,  16'hA5A5};
      vecs[8]  = '{SRA, 16'hA5A5, 4'd0,  4'd9,  16'hA5A5};
      vecs[9]  = '{SLA, 16'h0002, 4'd4,  4'd10, 16'h0020};
      vecs[10] = '{SRL, 16'hF000, 4'd4,  4'd11, 16'h0F00};
      vecs[11] = '{SRA, 16'h4000, 4'd2,  4'd12, 16'h1000};
      vecs[12] = '{SLA, 16'hFFFF, 4'd8,  4'd13, 16'hFFFF};

      do_reset();

      // Single SRA, then check flags and counter after retire.
      issue(vecs[0], 1'b1);
      idle(3);
      chk("sra flag_n", 32'(flag_n), 32'd1);
      chk("sra retired_cnt", 32'(retired_cnt), 32'd1);

      // Back-to-back group.
      for (int i = 1; i <= 4; i++) issue(vecs[i], 1'b1);
      idle(3);
      chk("b2b retired_cnt", 32'(retired_cnt), 32'd5);
      chk("b2b flag_z", 32'(flag_z), 32'd1);

      for (int i = 5; i < 13; i++) issue(vecs[i], 1'b1);
      idle(3);

      // Back-pressure: A, B fill the pipe, C is held until out_ready rises.
      issue(vecs[9], 1'b0);
      issue(vecs[10], 1'b0);
      issue(vecs[11], 1'b0);
      issue(vecs[11], 1'b0);
      issue(vecs[11], 1'b1);
      idle(4);

      // Flush with both stages full and out_ready high.
      issue(vecs[1], 1'b1);
      issue(vecs[2], 1'b1);
      cnt_save = m_cnt; fz_save = m_fz; fn_save = m_fn;
      step(1'b1, SLL, 16'h1234, 4'd1, 4'd14, 16'h2468, 1'b1, 1'b1);
      idle(2);
      chk("flush retired_cnt", 32'(retired_cnt), 32'(cnt_save));
      chk("flush flag_z", 32'(flag_z), 32'(fz_save));
      chk("flush flag_n", 32'(flag_n), 32'(fn_save));

      // Asynchronous reset with two operations in flight.
      issue(vecs[3], 1'b0);
      issue(vecs[4], 1'b0);
      do_reset();
      issue(vecs[10], 1'b1);
      idle(3);
      chk("post-reset retired_cnt", 32'(retired_cnt), 32'd1);

      // Random traffic against the arithmetic model.
      for (int i = 0; i < 400; i++) begin
         r.mode  = 2'($urandom_range(0, 3));
         r.src   = 16'($urandom);
         r.shamt = 4'($urandom_range(0, 15));
         r.rd    = 4'($urandom_range(0, 15));
         r.exp   = model(r.mode, r.src, r.shamt);
         step(1'($urandom_range(0, 3) != 0), r.mode, r.src, r.shamt, r.rd, r.exp,
              1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0));
      end
      idle(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
